// File: rtl/register_file_n_pkg.sv
// Shared constants and helpers for the Mini-SRC general-purpose register bank.
package register_file_n_pkg;

  localparam int unsigned REG_WIDTH = 32;
  localparam int unsigned REG_COUNT = 16;
  // Index of the register that reads as zero in base-address mode
  localparam int unsigned R0 = 0;

  // Address width for a bank of the given depth; never narrower than one bit
  function automatic int unsigned addr_width(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/register_file_n_if.sv
// Write port, two read ports and written[] status of the register bank.
interface register_file_n_if
  import register_file_n_pkg::*;
#(
  parameter int unsigned WIDTH = REG_WIDTH,
  parameter int unsigned DEPTH = REG_COUNT
) ();

  localparam int unsigned ADDR_W = addr_width(DEPTH);

  logic              write;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic [ADDR_W-1:0] ra_addr;
  logic [ADDR_W-1:0] rb_addr;
  logic              ba_a;
  logic [WIDTH-1:0]  ra_data;
  logic [WIDTH-1:0]  rb_data;
  logic [DEPTH-1:0]  written;

  modport master (
    output write, waddr, wdata, ra_addr, rb_addr, ba_a,
    input  ra_data, rb_data, written
  );

  modport slave (
    input  write, waddr, wdata, ra_addr, rb_addr, ba_a,
    output ra_data, rb_data, written
  );

endinterface

// File: rtl/register_w.sv
// Single WIDTH-bit register with write enable and asynchronous active-low clear.
module register_w #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Storage: load d when enabled, clear immediately on clr
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/register_file_n.sv
// DEPTH x WIDTH register bank: one write port, read ports A/B with optional
// bypass, R0-reads-zero gating on port A and selectable read latency.
module register_file_n
  import register_file_n_pkg::*;
#(
  parameter int unsigned WIDTH        = REG_WIDTH,
  parameter int unsigned DEPTH        = REG_COUNT,
  parameter int unsigned READ_LATENCY = 0,
  parameter int unsigned BYPASS       = 1
) (
  input logic        clk,
  input logic        clr,
  register_file_n_if.slave bus
);

  localparam int unsigned       ADDR_W  = addr_width(DEPTH);
  localparam logic [ADDR_W:0]   DepthA  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] R0Addr  = ADDR_W'(R0);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] we;
  logic [DEPTH-1:0] written_q;
  logic             wr_ok;
  logic [WIDTH-1:0] raw_a;
  logic [WIDTH-1:0] raw_b;

  // A write takes effect only out of reset and to an existing register
  assign wr_ok = bus.write & clr & ({1'b0, bus.waddr} < DepthA);

  // Per-register write enables decoded from waddr
  always_comb begin
    we = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      we[i] = wr_ok && (bus.waddr == ADDR_W'(i));
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    register_w #(
      .WIDTH (WIDTH)
    ) u_reg (
      .clk (clk),
      .clr (clr),
      .en  (we[i]),
      .d   (bus.wdata),
      .q   (regs[i])
    );
  end

  // Sticky written flags, cleared only by clr
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      written_q <= '0;
    end else begin
      written_q <= written_q | we;
    end
  end

  // Read muxes: out-of-range reads give 0, bypass forwards wdata, BA gate wins on A
  always_comb begin
    raw_a = '0;
    raw_b = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (bus.ra_addr == ADDR_W'(i)) raw_a = regs[i];
      if (bus.rb_addr == ADDR_W'(i)) raw_b = regs[i];
    end
    if ((BYPASS != 0) && wr_ok) begin
      if (bus.waddr == bus.ra_addr) raw_a = bus.wdata;
      if (bus.waddr == bus.rb_addr) raw_b = bus.wdata;
    end
    if (bus.ba_a && (bus.ra_addr == R0Addr)) raw_a = '0;
  end

  if (READ_LATENCY != 0) begin : g_lat1
    logic [WIDTH-1:0] ra_q;
    logic [WIDTH-1:0] rb_q;

    // Registered read: data follows the address by one cycle
    always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
        ra_q <= '0;
        rb_q <= '0;
      end else begin
        ra_q <= raw_a;
        rb_q <= raw_b;
      end
    end

    assign bus.ra_data = ra_q;
    assign bus.rb_data = rb_q;
  end else begin : g_lat0
    assign bus.ra_data = raw_a;
    assign bus.rb_data = raw_b;
  end

  assign bus.written = written_q;

endmodule
